// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch controller
//
// Purpose : FSM state encoding, instruction size, buffer entry layout and the
//           sequential-PC helper used by the fetch controller and its buffer.
// Ports   : none (package).

`ifndef PC_RESET
`define PC_RESET 32'h0000_0000
`endif

package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_TRAP = 2'd2
    } fetch_state_e;

    localparam int INSTR_BYTES = 4;
    localparam int ENTRY_W     = 64;

    // One buffered instruction; pc sits in the upper half of the 64-bit entry.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Sequential fetch address; wraps modulo 2^32 without any flag.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous instruction buffer with flush
//
// Purpose : Small circular FIFO holding {pc, instr} entries between the ROM
//           response path and the core. Flush empties it in one cycle.
// Ports   : clk, rst          clock, synchronous active-high reset
//           push_i/push_data_i write an entry
//           pop_i             drop the head entry (ignored when empty)
//           flush_i           discard all entries (wins over push/pop)
//           head_o            entry at the head (stale data when empty)
//           count_o           current occupancy

module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    logic full;
    logic empty;
    logic do_push;
    logic do_pop;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop_i & ~empty;
    // A push into a full buffer is legal only when the head leaves the same cycle.
    assign do_push = push_i & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Upstream credit accounting must never let an entry be lost.
    no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push_i && full && !pop_i && !flush_i));

endmodule

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - fetch sequencer between IF stage and instruction ROM
//
// Purpose : Issues sequential word-aligned ROM reads under credit control,
//           tags returned words with their PC, buffers them for the core and
//           flushes/restarts on redirect.
// Config  : FETCH_MISALIGN_CHK_EN - misaligned redirect raises sticky
//           o_misalign and parks the fetcher in S_TRAP. Undefined: redirect
//           target low bits are forced to zero and o_misalign is absent.
// Ports   : clk, rst                  clock, synchronous active-high reset
//           i_fetch_en                allow issuing new ROM reads
//           i_redirect/i_redirect_pc  flush and restart at a new PC
//           o_mem_addr/o_mem_stb      ROM read request (combinational)
//           i_mem_data/i_mem_data_vld ROM read data, one cycle after strobe
//           o_instr/o_instr_pc        buffer head and its PC
//           o_instr_vld/i_instr_rdy   core handshake
//           o_misalign                misaligned redirect seen (macro only)

`ifndef PC_RESET
`define PC_RESET 32'h0000_0000
`endif

module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = `PC_RESET,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_fetch_en,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_stb,
    input  logic [31:0] i_mem_data,
    input  logic        i_mem_data_vld,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    output logic        o_instr_vld,
    input  logic        i_instr_rdy
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic        o_misalign
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_e  state_q;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   fetch_pc_d;
    logic [31:0]   rsp_pc_q;
    logic          inflight_q;

    logic [31:0]   redirect_pc;
    logic          redirect_misaligned;
    logic [CW-1:0] occ;
    logic          pop;
    logic          push;
    logic          flush;
    logic [31:0]   used;
    logic          credit_ok;
    logic          stb;
    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;

`ifdef FETCH_MISALIGN_CHK_EN
    logic          misalign_q;

    assign redirect_pc         = i_redirect_pc;
    assign redirect_misaligned = i_redirect & (i_redirect_pc[1:0] != 2'b00);
`else
    assign redirect_pc         = i_redirect_pc & ~32'h0000_0003;
    assign redirect_misaligned = 1'b0;
`endif

    // Redirect cancels any pop: the head is being thrown away anyway.
    assign pop = o_instr_vld & i_instr_rdy & ~i_redirect;

    // Slots already spoken for (buffered + in flight), less the one leaving now,
    // must leave room for another word before we may issue.
    assign used      = 32'(occ) + 32'(inflight_q);
    assign credit_ok = used < (32'(FIFO_DEPTH) + 32'(pop));
    assign stb       = (state_q == S_RUN) & ~i_redirect & credit_ok;

    // inflight_q gates the response so a word requested before reset or
    // redirect never lands in the buffer.
    assign push  = i_mem_data_vld & inflight_q & ~i_redirect;
    assign flush = i_redirect | (state_q == S_TRAP);

    assign push_entry.pc    = rsp_pc_q;
    assign push_entry.instr = i_mem_data;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (i_redirect) begin
            fetch_pc_d = redirect_pc;
        end else if (stb) begin
            fetch_pc_d = next_pc(fetch_pc_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= '0;
            inflight_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= stb;
            if (stb) begin
                rsp_pc_q <= fetch_pc_q;
            end

            if (redirect_misaligned) begin
                state_q <= S_TRAP;
`ifdef FETCH_MISALIGN_CHK_EN
                misalign_q <= 1'b1;
`endif
            end else if (i_redirect && state_q == S_TRAP) begin
                // Aligned redirect releases the trap straight into the mode
                // the core currently asks for.
                state_q <= i_fetch_en ? S_RUN : S_IDLE;
`ifdef FETCH_MISALIGN_CHK_EN
                misalign_q <= 1'b0;
`endif
            end else begin
                case (state_q)
                    S_IDLE:  if (i_fetch_en)  state_q <= S_RUN;
                    S_RUN:   if (!i_fetch_en) state_q <= S_IDLE;
                    S_TRAP:  state_q <= S_TRAP;
                    default: state_q <= S_IDLE;
                endcase
`ifdef FETCH_MISALIGN_CHK_EN
                if (i_redirect) begin
                    misalign_q <= 1'b0;
                end
`endif
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (flush),
        .head_o      (head_entry),
        .count_o     (occ)
    );

    assign o_mem_addr  = fetch_pc_q;
    assign o_mem_stb   = stb;
    assign o_instr     = head_entry.instr;
    assign o_instr_pc  = head_entry.pc;
    assign o_instr_vld = (occ != '0);
`ifdef FETCH_MISALIGN_CHK_EN
    assign o_misalign  = misalign_q;
`endif

endmodule
